mem_arbiter: RTL

Shares the single 256-bit off-chip data-memory port between the instruction cache and the data cache of the pipelined RISC-V CPU. It accepts one line-sized read or write from each requester and serializes the two onto the port, one transaction at a time. It holds the memory request until the memory acknowledges, then returns a registered ack and read data to the winning requester. It sits between the two cache controllers and the memory interface (mem_data_i/o, mem_addr_o, mem_enable_o, mem_write_o, mem_ack_i).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids
// and default address/line widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between icache and dcache requests.
// Ports: ic_req, dc_req, last_grant in; any_req, winner out.
// MEM_ARB_RR_EN: round-robin on ties; otherwise dcache always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    ic_req,
   input  logic    dc_req,
   input  req_id_t last_grant,
   output logic    any_req,
   output req_id_t winner
);

`ifndef MEM_ARB_RR_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

   always_comb begin
      any_req = ic_req | dc_req;
      winner  = REQ_I;
      unique case ({ic_req, dc_req})
         2'b11: begin
`ifdef MEM_ARB_RR_EN
            // favour whoever was not served last
            winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
            winner = REQ_D;
`endif
         end
         2'b01:   winner = REQ_D;
         2'b10:   winner = REQ_I;
         default: winner = REQ_I;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes icache/dcache line transfers onto one memory port.
// Ports: clk_i, rst_i (sync, active-low), ic_*/dc_* requester
// side (req, write, addr, data in; ack, data out), mem_* memory side.
// All outputs registered. MEM_ARB_RR_EN selects round-robin ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_req_i,
   input  logic              ic_write_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic [DATA_W-1:0] ic_data_i,
   output logic              ic_ack_o,
   output logic [DATA_W-1:0] ic_data_o,
   input  logic              dc_req_i,
   input  logic              dc_write_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [DATA_W-1:0] dc_data_i,
   output logic              dc_ack_o,
   output logic [DATA_W-1:0] dc_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);

   arb_state_t        state, state_n;
   req_id_t           last_grant, last_n;
   req_id_t           winner;
   logic              any_req;
   logic              en_n, wr_n;
   logic              ic_ack_n, dc_ack_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] mdo_n, ic_data_n, dc_data_n;

   mem_arb_pick u_pick (
      .ic_req     (ic_req_i),
      .dc_req     (dc_req_i),
      .last_grant (last_grant),
      .any_req    (any_req),
      .winner     (winner)
   );

   always_comb begin
      state_n   = state;
      last_n    = last_grant;
      en_n      = mem_enable_o;
      wr_n      = mem_write_o;
      addr_n    = mem_addr_o;
      mdo_n     = mem_data_o;
      ic_ack_n  = 1'b0;
      dc_ack_n  = 1'b0;
      ic_data_n = ic_data_o;
      dc_data_n = dc_data_o;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               en_n = 1'b1;
               if (winner == REQ_D) begin
                  state_n = GNT_D;
                  wr_n    = dc_write_i;
                  addr_n  = dc_addr_i;
                  mdo_n   = dc_data_i;
               end else begin
                  state_n = GNT_I;
                  wr_n    = ic_write_i;
                  addr_n  = ic_addr_i;
                  mdo_n   = ic_data_i;
               end
            end
         end
         GNT_I: begin
            if (mem_ack_i) begin
               state_n   = DONE;
               ic_ack_n  = 1'b1;
               ic_data_n = mem_data_i;
               en_n      = 1'b0;
               wr_n      = 1'b0;
               last_n    = REQ_I;
            end
         end
         GNT_D: begin
            if (mem_ack_i) begin
               state_n   = DONE;
               dc_ack_n  = 1'b1;
               dc_data_n = mem_data_i;
               en_n      = 1'b0;
               wr_n      = 1'b0;
               last_n    = REQ_D;
            end
         end
         // requests ignored here so a held req is not served twice
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         last_grant   <= REQ_I;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         ic_ack_o     <= 1'b0;
         dc_ack_o     <= 1'b0;
         ic_data_o    <= '0;
         dc_data_o    <= '0;
      end else begin
         state        <= state_n;
         last_grant   <= last_n;
         mem_enable_o <= en_n;
         mem_write_o  <= wr_n;
         mem_addr_o   <= addr_n;
         mem_data_o   <= mdo_n;
         ic_ack_o     <= ic_ack_n;
         dc_ack_o     <= dc_ack_n;
         ic_data_o    <= ic_data_n;
         dc_data_o    <= dc_data_n;
      end
   end

endmodule
